// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states and port ids.
// Optional error checking in dmem_arbiter is enabled by DMEM_ARB_ERR_CHECK_EN.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic PORT_MEM = 1'b0;
   localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; last_winner advances only when adv is high.
// Ties go to the port that did not win last time.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt
);

   logic r_last;

   always_comb begin
      gnt = req;
      if (&req) begin
         gnt = (r_last == PORT_DBG) ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last <= PORT_DBG;
      end else if (adv && (|req)) begin
         r_last <= gnt[1];
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage and a debug port.
// Define DMEM_ARB_ERR_CHECK_EN to add err0/err1 for misaligned/out-of-range.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [31:0]       addr0,
   input  logic [31:0]       addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
`ifdef DMEM_ARB_ERR_CHECK_EN
   output logic              err0,
   output logic              err1,
`endif
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t              r_state;
   state_t              w_next;
   logic                r_we;
   logic [ADDR_W-1:0]   r_idx;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_win;
   logic                r_err;
   logic [DATA_W-1:0]   r_rdata;

   logic [1:0]          w_gnt;
   logic                w_take;
   logic                w_sel;
   logic [31:0]         w_addr;
   logic                w_bad;
   logic                w_done;
   logic                w_err;
   logic                w_unused_addr;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({req1, req0}),
      .adv   (w_take),
      .gnt   (w_gnt)
   );

   assign w_take = (r_state == IDLE) && (req0 || req1) && !reset;
   assign w_sel  = w_gnt[1];
   assign w_addr = w_sel ? addr1 : addr0;

`ifdef DMEM_ARB_ERR_CHECK_EN
   assign w_bad = (w_addr[1:0] != 2'b00) ||
                  (w_addr[31:ADDR_W+2] != '0);
`else
   assign w_bad = 1'b0;
`endif

   // Bits outside the word index are dropped when checking is off
   assign w_unused_addr = ^{w_addr[31:ADDR_W+2], w_addr[1:0]};

   always_comb begin
      w_next    = r_state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      w_done    = 1'b0;
      w_err     = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (r_state)
         IDLE: begin
            if (w_take) begin
               gnt0   = w_gnt[0];
               gnt1   = w_gnt[1];
               w_next = w_bad ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            mem_addr  = r_idx;
            mem_wdata = r_wdata;
            mem_write = r_we;
            mem_read  = ~r_we;
            if (r_we) begin
               w_done = 1'b1;
               w_next = IDLE;
            end else begin
               w_next = RESP;
            end
         end
         RESP: begin
            w_done = 1'b1;
            w_err  = r_err;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign done0 = w_done && !reset && (r_win == PORT_MEM);
   assign done1 = w_done && !reset && (r_win == PORT_DBG);
   assign busy  = (r_state != IDLE) && !reset;
   assign rdata = r_rdata;

`ifdef DMEM_ARB_ERR_CHECK_EN
   assign err0 = w_err && !reset && (r_win == PORT_MEM);
   assign err1 = w_err && !reset && (r_win == PORT_DBG);
`else
   logic w_unused_err;
   assign w_unused_err = w_err;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_win   <= PORT_MEM;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_we    <= w_sel ? we1 : we0;
            r_idx   <= w_addr[ADDR_W+1:2];
            r_wdata <= w_sel ? wdata1 : wdata0;
            r_win   <= w_sel;
            r_err   <= w_bad;
         end
         if ((r_state == ACCESS) && !r_we) begin
            r_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a transaction-level model.
// Checks err0/err1 when built with DMEM_ARB_ERR_CHECK_EN.
module tb_dmem_arbiter;

   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [31:0]   addr0 = 0, addr1 = 0;
   logic [DW-1:0] wdata0 = 0, wdata1 = 0;
   logic          gnt0, gnt1, done0, done1, busy;
   logic          mem_write, mem_read;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata, rdata;
   logic          err0, err1;

   logic [DW-1:0] ram [2**AW];
   logic [DW-1:0] ref_mem [2**AW];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
`ifdef DMEM_ARB_ERR_CHECK_EN
      .err0(err0), .err1(err1),
`endif
      .rdata(rdata), .busy(busy),
      .mem_write(mem_write), .mem_read(mem_read),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

`ifndef DMEM_ARB_ERR_CHECK_EN
   assign err0 = 1'b0;
   assign err1 = 1'b0;
`endif

   always @(posedge clk) if (mem_write) ram[mem_addr] <= mem_wdata;
   assign mem_rdata = ram[mem_addr];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      tick();
      reset = 1'b1;
      req0 = 0; req1 = 0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      logic [7:0] o;
      repeat (2) @(posedge clk);
      @(negedge clk);
      o = {gnt0, gnt1, done0, done1, busy, mem_write, mem_read, |rdata};
      checks++;
      if (o !== 8'h00) begin
         errors++;
         $display("FAIL reset_outs got=%b exp=00000000", o);
      end
      tick();
      reset = 1'b0;
      @(negedge clk);
      o = {gnt0, gnt1, done0, done1, busy, mem_write, mem_read,
           |{mem_addr, mem_wdata, rdata}};
      checks++;
      if (o !== 8'h00) begin
         errors++;
         $display("FAIL idle_outs got=%b exp=00000000", o);
      end
   endtask

   task automatic test_write_read;
      tick();
      req0 = 1; we0 = 1; addr0 = 32'h8; wdata0 = 32'hDEADBEEF;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, busy} !== 3'b100) begin
         errors++;
         $display("FAIL wr_gnt got=%b exp=100", {gnt0, gnt1, busy});
      end
      tick();
      req0 = 0;
      @(negedge clk);
      checks++;
      if ({mem_write, mem_read, done0, busy} !== 4'b1011 ||
          mem_addr !== 4'd2 || mem_wdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_access got=%b addr=%0d wd=%h exp=1011 2 deadbeef",
                  {mem_write, mem_read, done0, busy}, mem_addr, mem_wdata);
      end
      ref_mem[2] = 32'hDEADBEEF;
      tick();
      req0 = 1; we0 = 0; addr0 = 32'h8;
      @(negedge clk);
      checks++;
      if ({busy, done0, gnt0} !== 3'b001) begin
         errors++;
         $display("FAIL wr_turn got=%b exp=001", {busy, done0, gnt0});
      end
      tick();
      req0 = 0;
      @(negedge clk);
      checks++;
      if ({mem_read, mem_write, done0} !== 3'b100 || mem_addr !== 4'd2) begin
         errors++;
         $display("FAIL rd_access got=%b addr=%0d exp=100 2",
                  {mem_read, mem_write, done0}, mem_addr);
      end
      tick();
      @(negedge clk);
      checks++;
      if (done0 !== 1'b1 || rdata !== 32'hDEADBEEF || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL rd_done got=%b rdata=%h exp=1 deadbeef", done0, rdata);
      end
   endtask

   task automatic test_round_robin;
      int w;
      logic ph;
      apply_reset();
      req0 = 1; we0 = 0; addr0 = 32'h10;
      req1 = 1; we1 = 0; addr1 = 32'h14;
      for (int t = 0; t < 12; t++) begin
         if (t > 0) tick();
         @(negedge clk);
         w  = (t / 3) % 2;
         ph = (t % 3 == 0);
         checks++;
         if (gnt0 !== (ph && w == 0) || gnt1 !== (ph && w == 1) ||
             busy !== !ph) begin
            errors++;
            $display("FAIL rr_gnt t=%0d got=%b%b%b exp=%b%b%b", t, gnt0, gnt1,
                     busy, ph && w == 0, ph && w == 1, !ph);
         end
         if (t % 3 == 2) begin
            checks++;
            if (done0 !== (w == 0) || done1 !== (w == 1) ||
                rdata !== ref_mem[w == 1 ? 5 : 4]) begin
               errors++;
               $display("FAIL rr_done t=%0d got=%b%b %h exp=%0d %h", t, done0,
                        done1, rdata, w, ref_mem[w == 1 ? 5 : 4]);
            end
         end
      end
      tick();
      req0 = 0; req1 = 0;
   endtask

   task automatic test_reset_in_access;
      tick();
      req1 = 1; we1 = 0; addr1 = 32'h4;
      @(negedge clk);
      checks++;
      if (gnt1 !== 1'b1) begin
         errors++;
         $display("FAIL rst_acc_gnt got=%b exp=1", gnt1);
      end
      tick();
      req1 = 0; reset = 1;
      @(negedge clk);
      checks++;
      if (mem_read !== 1'b1) begin
         errors++;
         $display("FAIL rst_acc_read got=%b exp=1", mem_read);
      end
      tick();
      reset = 0;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) tick();
         @(negedge clk);
         checks++;
         if ({busy, done1, mem_read, mem_write} !== 4'b0000 ||
             rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL rst_acc_after i=%0d got=%b rdata=%h exp=0000 0", i,
                     {busy, done1, mem_read, mem_write}, rdata);
         end
      end
   endtask

   task automatic test_wrap;
      tick();
      req0 = 1; we0 = 1; addr0 = 32'h44; wdata0 = 32'h12345678;
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1) begin
         errors++;
         $display("FAIL wrap_gnt got=%b exp=1", gnt0);
      end
      tick();
      req0 = 0;
      @(negedge clk);
      checks++;
`ifdef DMEM_ARB_ERR_CHECK_EN
      if ({mem_write, mem_read, done0, err0} !== 4'b0011) begin
         errors++;
         $display("FAIL wrap_err got=%b exp=0011",
                  {mem_write, mem_read, done0, err0});
      end
`else
      if ({mem_write, done0} !== 2'b11 || mem_addr !== 4'd1) begin
         errors++;
         $display("FAIL wrap_addr got=%b addr=%0d exp=11 1",
                  {mem_write, done0}, mem_addr);
      end
      ref_mem[1] = 32'h12345678;
`endif
      tick();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wrap_idle got=%b exp=0", busy);
      end
   endtask

`ifdef DMEM_ARB_ERR_CHECK_EN
   task automatic test_err;
      logic [DW-1:0] prev;
      prev = rdata;
      tick();
      req0 = 1; we0 = 0; addr0 = 32'h45;
      @(negedge clk);
      tick();
      req0 = 0;
      @(negedge clk);
      checks++;
      if ({mem_write, mem_read, done0, err0, err1} !== 5'b00110 ||
          rdata !== prev) begin
         errors++;
         $display("FAIL err_resp got=%b rdata=%h exp=00110 %h",
                  {mem_write, mem_read, done0, err0, err1}, rdata, prev);
      end
   endtask
`endif

   task automatic test_random;
      bit            pv [2];
      bit            pwe [2];
      logic [31:0]   pa [2];
      logic [DW-1:0] pd [2];
      int            done_t [2];
      bit            done_e [2];
      int            t, free_t, acc_t, rd_t;
      bit            last, acc_we, xb, e, win;
      logic [AW-1:0] acc_idx, idx;
      logic [DW-1:0] acc_wd, rd_val, xr;
      logic [31:0]   hi, lo;
      logic [1:0]    eg;
      apply_reset();
      free_t = 0; acc_t = -1; rd_t = -1; last = 1; xr = '0;
      for (int p = 0; p < 2; p++) begin
         pv[p] = 0; done_t[p] = -1; done_e[p] = 0;
      end
      for (t = 0; t < 400; t++) begin
         if (t > 0) tick();
         req0 = pv[0]; we0 = pwe[0]; addr0 = pa[0]; wdata0 = pd[0];
         req1 = pv[1]; we1 = pwe[1]; addr1 = pa[1]; wdata1 = pd[1];
         @(negedge clk);
         if (t == rd_t) xr = rd_val;
         xb = (t < free_t);
         eg = 2'b00;
         win = 0;
         if (!xb && (pv[0] || pv[1])) begin
            win = (pv[0] && pv[1]) ? ~last : pv[1];
            eg[win] = 1'b1;
         end
         checks++;
         if ({gnt1, gnt0} !== eg || busy !== xb ||
             done0 !== (done_t[0] == t) || done1 !== (done_t[1] == t) ||
             err0 !== (done_t[0] == t && done_e[0]) ||
             err1 !== (done_t[1] == t && done_e[1]) || rdata !== xr) begin
            errors++;
            $display("FAIL rnd_ctl t=%0d got g=%b b=%b d=%b%b e=%b%b r=%h exp g=%b b=%b d=%b%b r=%h",
                     t, {gnt1, gnt0}, busy, done0, done1, err0, err1, rdata,
                     eg, xb, done_t[0] == t, done_t[1] == t, xr);
         end
         checks++;
         if (mem_write !== (acc_t == t && acc_we) ||
             mem_read !== (acc_t == t && !acc_we) ||
             (acc_t == t && mem_addr !== acc_idx) ||
             (acc_t == t && acc_we && mem_wdata !== acc_wd)) begin
            errors++;
            $display("FAIL rnd_mem t=%0d got w=%b r=%b a=%0d d=%h exp a=%0d d=%h",
                     t, mem_write, mem_read, mem_addr, mem_wdata, acc_idx, acc_wd);
         end
         if (eg != 2'b00) begin
            last = win;
            idx = pa[win][AW+1:2];
`ifdef DMEM_ARB_ERR_CHECK_EN
            e = (pa[win][1:0] != 0) || ((pa[win] >> (AW + 2)) != 0);
`else
            e = 0;
`endif
            done_e[win] = e;
            if (e) begin
               done_t[win] = t + 1; free_t = t + 2;
            end else if (pwe[win]) begin
               acc_t = t + 1; acc_we = 1; acc_idx = idx; acc_wd = pd[win];
               done_t[win] = t + 1; free_t = t + 2;
               ref_mem[idx] = pd[win];
            end else begin
               acc_t = t + 1; acc_we = 0; acc_idx = idx;
               done_t[win] = t + 2; free_t = t + 3;
               rd_t = t + 2; rd_val = ref_mem[idx];
            end
            pv[win] = 0;
         end
         for (int p = 0; p < 2; p++) begin
            if (!pv[p] && ($urandom_range(2) != 0)) begin
               hi = ($urandom_range(7) == 0) ? $urandom : 32'h0;
               lo = ($urandom_range(7) == 0) ? 32'($urandom_range(3)) : 32'h0;
               pv[p] = 1;
               pwe[p] = $urandom_range(1) == 1;
               pa[p] = (hi << (AW + 2)) | (32'($urandom_range(15)) << 2) | lo;
               pd[p] = $urandom;
            end
         end
      end
      tick();
      req0 = 0; req1 = 0;
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) begin
         ram[i] = $urandom | 32'h1;
         ref_mem[i] = ram[i];
      end
      test_reset();
      test_write_read();
      test_round_robin();
      test_reset_in_access();
      test_wrap();
`ifdef DMEM_ARB_ERR_CHECK_EN
      test_err();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
